// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg : forwarding-select encodings and scoreboard slot layout shared by
//           the decode-stage hazard controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int RADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic               v;
    logic               we;
    logic [RADDR_W-1:0] dest;
    logic               ld;
  } sb_slot_t;

endpackage

`default_nettype wire

// File: rtl/hz_match.sv
//------------------------------------------------------------------------------
// hz_match : priority matcher of one source operand against the EX/MEM/WB
//            scoreboard slots; youngest writer wins.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hz_match
  import cpu_pkg::*;
(
  input  logic [RADDR_W-1:0] src_i,
  input  logic               used_i,
  input  sb_slot_t           ex_i,
  input  sb_slot_t           mem_i,
  input  sb_slot_t           wb_i,
  output logic [1:0]         fwd_sel_o,
  output logic               load_hit_o
);

  logic w_rd_ok;
  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  // r0 reads as zero, so it never takes a forwarded value
  assign w_rd_ok   = used_i & (src_i != '0);
  assign w_hit_ex  = w_rd_ok & ex_i.v  & ex_i.we  & (ex_i.dest  == src_i);
  assign w_hit_mem = w_rd_ok & mem_i.v & mem_i.we & (mem_i.dest == src_i);
  assign w_hit_wb  = w_rd_ok & wb_i.v  & wb_i.we  & (wb_i.dest  == src_i);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (w_hit_ex)       fwd_sel_o = FWD_EX;
    else if (w_hit_mem) fwd_sel_o = FWD_MEM;
    else if (w_hit_wb)  fwd_sel_o = FWD_WB;
  end

  assign load_hit_o = w_hit_ex & ex_i.ld;

endmodule

`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
//------------------------------------------------------------------------------
// id_hazard_ctrl : decode-stage interlock and forwarding scheduler driven by a
//                  shadow scoreboard of in-flight EX/MEM/WB register writers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_hazard_ctrl #(
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic               id_cancel,
  input  logic [RADDR_W-1:0] id_src1,
  input  logic               id_src1_used,
  input  logic [RADDR_W-1:0] id_src2,
  input  logic               id_src2_used,
  input  logic               id_gr_we,
  input  logic [RADDR_W-1:0] id_dest,
  input  logic               id_is_load,
  input  logic               EX_allow_in,
  input  logic               ex_fire,
  input  logic               mem_fire,
  input  logic               wb_fire,
  output logic               ID_ready_go,
  output logic [1:0]         fwd_sel1,
  output logic [1:0]         fwd_sel2,
  output logic [CNT_W-1:0]   stall_cnt
);

  import cpu_pkg::*;

  sb_slot_t          ex_q, ex_d;
  sb_slot_t          mem_q, mem_d;
  sb_slot_t          wb_q, wb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_hit1, load_hit2;
  logic              id_live, id_fire, stall;

  hz_match u_match1 (
    .src_i      (id_src1),
    .used_i     (id_src1_used),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .fwd_sel_o  (fwd_sel1),
    .load_hit_o (load_hit1)
  );

  hz_match u_match2 (
    .src_i      (id_src2),
    .used_i     (id_src2_used),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .fwd_sel_o  (fwd_sel2),
    .load_hit_o (load_hit2)
  );

  // Squashed or empty decode slots never hold the pipeline back
  assign id_live     = id_valid & ~id_cancel;
  assign stall       = id_live & (load_hit1 | load_hit2);
  assign ID_ready_go = ~stall;
  assign id_fire     = id_live & ID_ready_go & EX_allow_in;
  assign stall_cnt   = cnt_q;

  always_comb begin
    ex_d = ex_q;
    if (id_fire) begin
      ex_d.v    = 1'b1;
      ex_d.we   = id_gr_we;
      ex_d.dest = id_dest;
      ex_d.ld   = id_is_load;
    end else if (ex_fire) begin
      ex_d.v = 1'b0;
    end

    mem_d = mem_q;
    if (ex_fire)       mem_d   = ex_q;
    else if (mem_fire) mem_d.v = 1'b0;

    wb_d = wb_q;
    if (mem_fire)     wb_d   = mem_q;
    else if (wb_fire) wb_d.v = 1'b0;

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_id_hazard_ctrl : directed scenarios plus random traffic against an
//                     in-bench model of the in-flight writer list.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_cancel, id_src1_used, id_src2_used;
  logic [4:0] id_src1, id_src2, id_dest;
  logic       id_gr_we, id_is_load, EX_allow_in, ex_fire, mem_fire, wb_fire;
  logic       ID_ready_go;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [3:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Model: age-ordered writer records, index 0 = EX (youngest), 2 = WB
  logic       m_v[3], m_we[3], m_ld[3];
  logic [4:0] m_dest[3];
  logic [3:0] m_cnt;
  logic [3:0] c0;

  id_hazard_ctrl #(.RADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .reset(rst), .id_valid(id_valid), .id_cancel(id_cancel),
    .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_gr_we(id_gr_we), .id_dest(id_dest), .id_is_load(id_is_load),
    .EX_allow_in(EX_allow_in), .ex_fire(ex_fire), .mem_fire(mem_fire),
    .wb_fire(wb_fire), .ID_ready_go(ID_ready_go),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_sel(input logic [4:0] src, input logic used);
    for (int s = 0; s < 3; s++)
      if (used && src != 0 && m_v[s] && m_we[s] && m_dest[s] == src)
        return 2'(s + 1);
    return 2'd0;
  endfunction

  function automatic logic exp_go();
    logic load_use;
    load_use = (exp_sel(id_src1, id_src1_used) == 2'd1 && m_ld[0]) ||
               (exp_sel(id_src2, id_src2_used) == 2'd1 && m_ld[0]);
    return !(id_valid && !id_cancel && load_use);
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) begin
      m_v[s] = 0; m_we[s] = 0; m_ld[s] = 0; m_dest[s] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step();
    logic go, issue;
    go    = exp_go();
    issue = id_valid && !id_cancel && go && EX_allow_in;
    if (id_valid && !id_cancel && !go && m_cnt != 4'hF) m_cnt = m_cnt + 1;
    if (mem_fire) begin
      m_v[2] = m_v[1]; m_we[2] = m_we[1]; m_dest[2] = m_dest[1]; m_ld[2] = m_ld[1];
    end else if (wb_fire) m_v[2] = 0;
    if (ex_fire) begin
      m_v[1] = m_v[0]; m_we[1] = m_we[0]; m_dest[1] = m_dest[0]; m_ld[1] = m_ld[0];
    end else if (mem_fire) m_v[1] = 0;
    if (issue) begin
      m_v[0] = 1; m_we[0] = id_gr_we; m_dest[0] = id_dest; m_ld[0] = id_is_load;
    end else if (ex_fire) m_v[0] = 0;
  endtask

  task automatic drive(input logic v, input logic cn, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2, input logic we,
                       input logic [4:0] d, input logic ld, input logic al,
                       input logic ef, input logic mf, input logic wf);
    id_valid = v; id_cancel = cn; id_src1 = s1; id_src1_used = u1;
    id_src2 = s2; id_src2_used = u2; id_gr_we = we; id_dest = d; id_is_load = ld;
    EX_allow_in = al; ex_fire = ef; mem_fire = mf; wb_fire = wf;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 5'd4, 1, 5'd4, 1, 1, 5'd4, 1, 1, 1, 1, 1);
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ID_ready_go !== 1'b1) begin errors++; $display("FAIL reset_go got=%b exp=1", ID_ready_go); end
    checks++; if (fwd_sel1 !== 2'd0) begin errors++; $display("FAIL reset_sel1 got=%0d exp=0", fwd_sel1); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 5'd1, 1, 5'd2, 1, 1, 5'd5, 0, 1, 1, 1, 1); tick();
    drive(1, 0, 5'd5, 1, 5'd7, 1, 1, 5'd6, 0, 1, 1, 1, 1); #1;
    checks++; if (ID_ready_go !== 1'b1) begin errors++; $display("FAIL b2b_go got=%b exp=1", ID_ready_go); end
    checks++; if (fwd_sel1 !== 2'd1) begin errors++; $display("FAIL b2b_sel1_ex got=%0d exp=1", fwd_sel1); end
    tick();
    drive(1, 0, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, 1); #1;
    checks++; if (fwd_sel1 !== 2'd2) begin errors++; $display("FAIL b2b_sel1_mem got=%0d exp=2", fwd_sel1); end
    tick();
    drain();
  endtask

  task automatic test_load_use();
    c0 = stall_cnt;
    drive(1, 0, 5'd1, 1, 5'd0, 0, 1, 5'd4, 1, 1, 1, 1, 1); tick();
    drive(1, 0, 5'd4, 1, 5'd4, 1, 1, 5'd8, 0, 1, 1, 1, 1); #1;
    checks++; if (ID_ready_go !== 1'b0) begin errors++; $display("FAIL lu_stall_go got=%b exp=0", ID_ready_go); end
    checks++; if (fwd_sel1 !== 2'd1 || fwd_sel2 !== 2'd1) begin errors++; $display("FAIL lu_stall_sel got=%0d/%0d exp=1/1", fwd_sel1, fwd_sel2); end
    tick(); #1;
    checks++; if (ID_ready_go !== 1'b1) begin errors++; $display("FAIL lu_release_go got=%b exp=1", ID_ready_go); end
    checks++; if (fwd_sel1 !== 2'd2 || fwd_sel2 !== 2'd2) begin errors++; $display("FAIL lu_release_sel got=%0d/%0d exp=2/2", fwd_sel1, fwd_sel2); end
    checks++; if (stall_cnt !== 4'(c0 + 4'd1)) begin errors++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, c0 + 4'd1); end
    tick();
    drain();
  endtask

  task automatic test_priority();
    drive(1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 1, 1, 1, 1); tick();
    drive(1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd1, 0, 1, 1, 1, 1); tick();
    drive(1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 1, 1, 1, 1); tick();
    drive(1, 0, 5'd9, 1, 5'd1, 1, 0, 5'd0, 0, 1, 1, 1, 1); #1;
    checks++; if (fwd_sel1 !== 2'd1) begin errors++; $display("FAIL prio_ex_over_wb got=%0d exp=1", fwd_sel1); end
    checks++; if (fwd_sel2 !== 2'd2) begin errors++; $display("FAIL prio_mem got=%0d exp=2", fwd_sel2); end
    tick();
    drive(1, 0, 5'd9, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0); #1;
    checks++; if (fwd_sel1 !== exp_sel(5'd9, 1'b1)) begin errors++; $display("FAIL prio_model got=%0d exp=%0d", fwd_sel1, exp_sel(5'd9, 1'b1)); end
    tick();
    drain();
  endtask

  task automatic test_r0_cancel();
    c0 = stall_cnt;
    drive(1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd0, 1, 1, 1, 1, 1); tick();
    drive(1, 0, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 1, 1, 1, 1); #1;
    checks++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0 || ID_ready_go !== 1'b1) begin
      errors++; $display("FAIL r0_nomatch got=%0d/%0d go=%b exp=0/0 go=1", fwd_sel1, fwd_sel2, ID_ready_go); end
    tick(); drain();
    drive(1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd4, 1, 1, 1, 1, 1); tick();
    drive(1, 1, 5'd4, 1, 5'd4, 1, 1, 5'd10, 0, 1, 1, 1, 1); #1;
    checks++; if (ID_ready_go !== 1'b1) begin errors++; $display("FAIL cancel_go got=%b exp=1", ID_ready_go); end
    tick();
    drive(1, 0, 5'd10, 1, 5'd4, 1, 0, 5'd0, 0, 1, 1, 1, 1); #1;
    checks++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd2) begin
      errors++; $display("FAIL cancel_noentry got=%0d/%0d exp=0/2", fwd_sel1, fwd_sel2); end
    checks++; if (stall_cnt !== c0) begin errors++; $display("FAIL cancel_cnt got=%0d exp=%0d", stall_cnt, c0); end
    tick(); drain();
  endtask

  task automatic test_backpressure();
    c0 = stall_cnt;
    drive(1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd4, 1, 1, 1, 1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 5'd4, 1, 5'd0, 0, 1, 5'd8, 0, 1, 0, 0, 0); #1;
      checks++; if (ID_ready_go !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got=%b exp=0", i, ID_ready_go); end
      tick();
    end
    checks++; if (stall_cnt !== 4'(c0 + 4'd3)) begin errors++; $display("FAIL bp_cnt got=%0d exp=%0d", stall_cnt, c0 + 4'd3); end
    drive(1, 0, 5'd4, 1, 5'd0, 0, 1, 5'd8, 0, 1, 1, 1, 1); tick(); #1;
    checks++; if (ID_ready_go !== 1'b1 || fwd_sel1 !== 2'd2) begin
      errors++; $display("FAIL bp_release go=%b sel=%0d exp go=1 sel=2", ID_ready_go, fwd_sel1); end
    tick(); drain();
  endtask

  task automatic test_saturation();
    drive(1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd4, 1, 1, 1, 1, 1); tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 5'd0, 0, 5'd4, 1, 1, 5'd8, 0, 1, 0, 0, 0); tick(); #1;
      checks++; if (stall_cnt !== m_cnt) begin errors++; $display("FAIL sat_step%0d got=%0d exp=%0d", i, stall_cnt, m_cnt); end
    end
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 0, 5'd4, 1, 5'd0, 0, 1, 5'd8, 0, 1, 0, 0, 0); #1;
    checks++; if (ID_ready_go !== 1'b0) begin errors++; $display("FAIL rms_pre go=%b exp=0", ID_ready_go); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ID_ready_go !== 1'b1) begin errors++; $display("FAIL rms_go got=%b exp=1", ID_ready_go); end
    checks++; if (fwd_sel1 !== 2'd0) begin errors++; $display("FAIL rms_sel got=%0d exp=0", fwd_sel1); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rms_cnt got=%0d exp=0", stall_cnt); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    logic [1:0] e1, e2;
    logic       eg;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 8) == 0,
            5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            ($urandom % 4) != 0, 5'($urandom_range(0, 3)), ($urandom % 3) == 0,
            ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0, 1'($urandom));
      #1;
      e1 = exp_sel(id_src1, id_src1_used);
      e2 = exp_sel(id_src2, id_src2_used);
      eg = exp_go();
      checks++; if (fwd_sel1 !== e1) begin errors++; $display("FAIL rnd_sel1 cyc=%0d got=%0d exp=%0d", i, fwd_sel1, e1); end
      checks++; if (fwd_sel2 !== e2) begin errors++; $display("FAIL rnd_sel2 cyc=%0d got=%0d exp=%0d", i, fwd_sel2, e2); end
      checks++; if (ID_ready_go !== eg) begin errors++; $display("FAIL rnd_go cyc=%0d got=%b exp=%b", i, ID_ready_go, eg); end
      checks++; if (stall_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_cnt); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_r0_cancel();
    test_backpressure();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
